// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency single-word read responder for the data cache
// refill port, backed by a word-addressed store with a side-band preload port.
module dmem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              mem_addr,
  input  logic                     mem_req,
  output logic [31:0]              mem_rdata,
  output logic                     mem_ready,
  output logic                     resp_err,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  output logic [31:0]              req_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [31:0]   store [DEPTH];
  logic [AW-1:0] req_idx;
  logic          req_oor;
  logic [AW-1:0] idx_q;
  logic          oor_q;
  logic [CW-1:0] cnt;
  logic [AW-1:0] rd_idx;
  logic          enter_resp;
  logic [31:0]   rd_q;

  // Word index and out-of-range flag of the incoming request
  assign req_idx = mem_addr[AW+1:2];
  assign req_oor = (mem_addr >> (AW + 2)) != 32'd0;

  // With LATENCY==1 the read happens on the acceptance edge, so use the live index
  assign rd_idx     = (state == IDLE) ? req_idx : idx_q;
  assign enter_resp = (state != RESP) && (state_nxt == RESP);

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mem_req) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt == CW'(1)) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Request capture and latency countdown
  always_ff @(posedge clk) begin
    if (state == IDLE && mem_req) begin
      idx_q <= req_idx;
      oor_q <= req_oor;
      cnt   <= CW'(LATENCY - 1);
    end else if (state == WAIT) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Store read on the edge entering RESP (read-before-write against preload)
  always_ff @(posedge clk) begin
    if (enter_resp) rd_q <= store[rd_idx];
  end

  // Preload write port; store contents survive reset
  always_ff @(posedge clk) begin
    if (load_en && !rst) store[load_addr] <= load_data;
  end

  // Registered response outputs and served-request counter
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
      resp_err  <= 1'b0;
      req_count <= 32'd0;
    end else if (state == RESP) begin
      mem_ready <= 1'b1;
      mem_rdata <= oor_q ? 32'd0 : rd_q;
      resp_err  <= oor_q;
      req_count <= req_count + 32'd1;
    end else begin
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
      resp_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=4 and a LATENCY=1 instance.
module tb_dmem_responder;

  localparam int unsigned L4 = 4;
  localparam int unsigned L1 = 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [31:0] cnt;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a4, a1, ld4, ld1, rd4, rd1, cnt4, cnt1;
  logic        r4, r1, le4, le1, rdy4, rdy1, err4, err1;
  logic [9:0]  la4, la1;

  exp_t        q4[$];
  exp_t        q1[$];
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  bit          mon_en = 1'b0;
  logic [31:0] m4 = 0;
  logic [31:0] m1 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH(1024), .LATENCY(L4)) u4 (
    .clk(clk), .rst(rst), .mem_addr(a4), .mem_req(r4), .mem_rdata(rd4),
    .mem_ready(rdy4), .resp_err(err4), .load_en(le4), .load_addr(la4),
    .load_data(ld4), .req_count(cnt4)
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(L1)) u1 (
    .clk(clk), .rst(rst), .mem_addr(a1), .mem_req(r1), .mem_rdata(rd1),
    .mem_ready(rdy1), .resp_err(err1), .load_en(le1), .load_addr(la1),
    .load_data(ld1), .req_count(cnt1)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  // Monitor for the LATENCY=4 instance
  always @(negedge clk) begin : mon4
    exp_t e;
    if (mon_en) begin
      if (rdy4 === 1'b1) begin
        if (q4.size() == 0) chk("l4_unexpected_ready", 32'd1, 32'd0);
        else begin
          e = q4.pop_front();
          chk("l4_ready_cycle", cyc, e.cyc);
          chk("l4_rdata", rd4, e.data);
          chk("l4_err", 32'(err4), 32'(e.err));
          chk("l4_count", cnt4, e.cnt);
        end
      end else begin
        chk("l4_ready_low", 32'(rdy4), 32'd0);
        chk("l4_idle_rdata", rd4, 32'd0);
        chk("l4_idle_err", 32'(err4), 32'd0);
      end
    end
  end

  // Monitor for the LATENCY=1 instance
  always @(negedge clk) begin : mon1
    exp_t e;
    if (mon_en) begin
      if (rdy1 === 1'b1) begin
        if (q1.size() == 0) chk("l1_unexpected_ready", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          chk("l1_ready_cycle", cyc, e.cyc);
          chk("l1_rdata", rd1, e.data);
          chk("l1_err", 32'(err1), 32'(e.err));
          chk("l1_count", cnt1, e.cnt);
        end
      end else begin
        chk("l1_ready_low", 32'(rdy1), 32'd0);
        chk("l1_idle_rdata", rd1, 32'd0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [31:0] d, input logic e, input int unsigned c);
    exp_t x;
    m4++;
    x.data = d; x.err = e; x.cnt = m4; x.cyc = c;
    q4.push_back(x);
  endtask

  task automatic push1(input logic [31:0] d, input logic e, input int unsigned c);
    exp_t x;
    m1++;
    x.data = d; x.err = e; x.cnt = m1; x.cyc = c;
    q1.push_back(x);
  endtask

  task automatic load4(input logic [9:0] a, input logic [31:0] d);
    le4 = 1'b1; la4 = a; ld4 = d;
    @(posedge clk); #1;
    le4 = 1'b0;
  endtask

  task automatic load1(input logic [9:0] a, input logic [31:0] d);
    le1 = 1'b1; la1 = a; ld1 = d;
    @(posedge clk); #1;
    le1 = 1'b0;
  endtask

  // Single request on the LATENCY=4 instance; req dropped right after acceptance
  task automatic issue4(input logic [31:0] addr, input logic [31:0] d, input logic e);
    a4 = addr; r4 = 1'b1;
    @(posedge clk); #1;
    push4(d, e, cyc + L4);
    r4 = 1'b0;
  endtask

  initial begin
    int unsigned t;
    rst = 1'b1;
    a4 = 0; a1 = 0; r4 = 0; r1 = 0;
    le4 = 0; le1 = 0; la4 = 0; la1 = 0; ld4 = 0; ld1 = 0;
    idle(2);
    rst = 1'b0;
    chk("rst_ready", 32'(rdy4), 32'd0);
    chk("rst_rdata", rd4, 32'd0);
    chk("rst_err", 32'(err4), 32'd0);
    chk("rst_count", cnt4, 32'd0);
    chk("rst_l1_count", cnt1, 32'd0);
    mon_en = 1'b1;

    // Basic in-range read
    load4(10'd5, 32'hCAFE_0005);
    issue4(32'h14, 32'hCAFE_0005, 1'b0);
    idle(6);

    // Out-of-range read
    issue4(32'h0000_1000, 32'h0, 1'b1);
    idle(6);

    // Back-to-back with mem_req held high
    load4(10'd2, 32'h22);
    a4 = 32'h8; r4 = 1'b1;
    @(posedge clk); #1;
    t = cyc;
    push4(32'h22, 1'b0, t + 4);
    push4(32'h22, 1'b0, t + 9);
    push4(32'h22, 1'b0, t + 14);
    idle(10);
    r4 = 1'b0;
    idle(6);

    // Reset during WAIT drops the transaction; load_en ignored under reset
    load4(10'd7, 32'h77);
    a4 = 32'h1C; r4 = 1'b1;
    @(posedge clk); #1;
    r4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; le4 = 1'b1; la4 = 10'd7; ld4 = 32'hBAD;
    @(posedge clk); #1;
    rst = 1'b0; le4 = 1'b0;
    m4 = 0; m1 = 0;
    chk("wrst_ready", 32'(rdy4), 32'd0);
    chk("wrst_rdata", rd4, 32'd0);
    chk("wrst_err", 32'(err4), 32'd0);
    chk("wrst_count", cnt4, 32'd0);
    idle(8);
    issue4(32'h1C, 32'h77, 1'b0);
    idle(6);

    // Preload on the RESP-entry edge: old data returned
    load4(10'd3, 32'hA);
    issue4(32'hC, 32'hA, 1'b0);
    idle(2);
    load4(10'd3, 32'hB);
    idle(4);

    // Preload during WAIT, two cycles earlier: new data returned
    load4(10'd3, 32'hA);
    issue4(32'hC, 32'hB, 1'b0);
    load4(10'd3, 32'hB);
    idle(6);

    // LATENCY=1 instance: response next cycle, issue interval 2
    load1(10'd9, 32'h99);
    a1 = 32'h24; r1 = 1'b1;
    @(posedge clk); #1;
    t = cyc;
    push1(32'h99, 1'b0, t + 1);
    push1(32'h99, 1'b0, t + 3);
    idle(2);
    r1 = 1'b0;
    idle(4);

    // Out-of-range on LATENCY=1
    a1 = 32'h8000_0000; r1 = 1'b1;
    @(posedge clk); #1;
    push1(32'h0, 1'b1, cyc + 1);
    r1 = 1'b0;
    idle(4);

    chk("drain_l4", 32'(q4.size()), 32'd0);
    chk("drain_l1", 32'(q1.size()), 32'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the data cache's refill interface. It answers the single-word read protocol (mem_addr / mem_req / mem_rdata / mem_ready) from a word-addressed backing store, with a fixed, parameterised access latency.
- A side-band preload port lets the testbench or boot logic write the store.
- It sits between the data cache's memory port and the top-level memory map. It also provides an out-of-range error pulse and a served-request counter.

Parameters:
- DEPTH, 1024, number of 32-bit words in the backing store. Must be a power of two, at least 2. Localparam AW = $clog2(DEPTH).
- LATENCY, 4, cycles from request capture to the mem_ready cycle. Must be at least 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_addr  in  32  byte address from the cache; bits [1:0] ignored.
- mem_req  in  1  read request, level; held with stable mem_addr until mem_ready is seen.
- mem_rdata  out  32  read data; valid only while mem_ready=1.
- mem_ready  out  1  one-cycle response strobe.
- resp_err  out  1  one-cycle strobe coincident with mem_ready when the address was out of range.
- load_en  in  1  preload write enable.
- load_addr  in  AW  preload word index.
- load_data  in  32  preload write data.
- req_count  out  32  number of completed responses, wrapping.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE. mem_ready=0, resp_err=0, mem_rdata=0, req_count=0.
  - Any in-flight transaction is dropped and no response is issued for it.
  - The store array is not cleared.
  - load_en is ignored while rst=1.
- Address decode:
  - idx = mem_addr[AW+1:2].
  - Out of range iff mem_addr[31:AW+2] != 0.
  - The address is captured at request acceptance and never re-sampled.
- FSM states: IDLE, WAIT, RESP.
  - IDLE:
    - If mem_req=1 at an edge: capture idx and the range flag, and load cnt = LATENCY-1.
    - Next state is RESP if LATENCY==1, otherwise WAIT.
    - mem_req=0 stays in IDLE.
  - WAIT:
    - cnt decrements each edge.
    - When cnt==1 at an edge, next state is RESP.
    - mem_req is ignored in this state; dropping it early does not cancel the transaction.
  - RESP:
    - mem_ready=1 for exactly one cycle. mem_rdata = store[idx], or 32'h0 if out of range. resp_err = out-of-range flag.
    - req_count increments by 1 (wraps 0xFFFFFFFF to 0).
    - Next state is always IDLE. mem_req sampled during the RESP cycle is ignored.
- Latency and throughput:
  - Request sampled at edge T gives mem_ready high in the cycle following edge T+LATENCY.
  - Minimum issue interval is LATENCY+1 cycles.
  - A requester that keeps mem_req high after the ready cycle starts a new transaction from IDLE with the then-current mem_addr.
- Data read timing:
  - The store is read on the edge entering RESP, registered into mem_rdata.
  - mem_rdata returns to 0 in the cycle after RESP (outputs registered; no combinational path from inputs).
- Preload:
  - load_en=1 writes store[load_addr] = load_data at the edge, in any state.
  - If the write targets idx on the same edge the read is registered, the old data is returned (read-before-write).
  - A preload write to idx during WAIT, before that edge, is visible in the response.
- No write path on the cache interface.

Test Plan:
- Preload store[5]=32'hCAFE_0005. Request mem_addr=32'h14 at edge 0 with LATENCY=4. Required: mem_ready=1 in the cycle after edge 4, with mem_rdata=32'hCAFE_0005, resp_err=0, req_count=1; mem_ready=0 the next cycle.
- Request mem_addr=32'h0000_1000 (DEPTH=1024, out of range). Required: mem_ready=1 with mem_rdata=0 and resp_err=1 after LATENCY; req_count increments.
- Hold mem_req high continuously at address 32'h8, with store[2]=32'h22. Required: mem_ready pulses every LATENCY+1=5 cycles, each with data 32'h22.
- Assert rst during WAIT (2 cycles after the request). Required: no mem_ready for that request; outputs 0; req_count=0; a new request after reset completes normally.
- Request idx 3 (old value 32'hA). load_en writes 32'hB to idx 3 on the RESP-entry edge. Required: returns 32'hA. Repeating with the write two cycles earlier returns 32'hB.
- LATENCY=1 build: request at edge 0. Required: mem_ready high in the cycle immediately after edge 1; issue interval 2 cycles.
